// File: rtl/store_narrow_unit_pkg.sv
// Shared encodings for the store narrowing path: op codes and byte-lane masks.
// Optional SWL/SWR support is controlled by STORE_NARROW_SWLR_EN (see store_lane_gen).
package store_narrow_unit_pkg;

  typedef enum logic [2:0] {
    ST_SB  = 3'd0,
    ST_SH  = 3'd1,
    ST_SW  = 3'd2,
    ST_SWL = 3'd3,
    ST_SWR = 3'd4
  } st_op_e;

  localparam logic [3:0] BE_BYTE0   = 4'b0001;
  localparam logic [3:0] BE_BYTE1   = 4'b0010;
  localparam logic [3:0] BE_BYTE2   = 4'b0100;
  localparam logic [3:0] BE_BYTE3   = 4'b1000;
  localparam logic [3:0] BE_HALF_LO = 4'b0011;
  localparam logic [3:0] BE_HALF_HI = 4'b1100;
  localparam logic [3:0] BE_WORD    = 4'b1111;

endpackage

// File: rtl/store_lane_gen.sv
// Combinational lane placement for stores: write data, byte enables, misalignment.
// SWL/SWR shifting exists only when STORE_NARROW_SWLR_EN is defined; otherwise ops 3/4 yield be=0.
module store_lane_gen
  import store_narrow_unit_pkg::*;
#(
  parameter int BIG_ENDIAN = 0
) (
  input  logic [2:0]  op,
  input  logic [1:0]  off,
  input  logic [31:0] data,
  output logic [31:0] wdata,
  output logic [3:0]  be,
  output logic        misaligned
);

  logic [1:0] lane;
  assign lane = (BIG_ENDIAN != 0) ? (2'd3 - off) : off;

`ifdef STORE_NARROW_SWLR_EN
  logic [4:0] sh_l;
  logic [4:0] sh_r;
  // Expressed in lane terms both endiannesses share one formula:
  // SWL fills lanes 0..lane with rt's top bytes, SWR fills lane..3 with rt's low bytes.
  assign sh_l = {(2'd3 - lane), 3'b000};
  assign sh_r = {lane, 3'b000};
`endif

  always_comb begin
    wdata      = '0;
    be         = '0;
    misaligned = 1'b0;
    case (op)
      ST_SB: begin
        wdata = {4{data[7:0]}};
        be    = BE_BYTE0 << lane;
      end
      ST_SH: begin
        wdata      = {2{data[15:0]}};
        misaligned = off[0];
        be         = (off[1] ^ (BIG_ENDIAN != 0)) ? BE_HALF_HI : BE_HALF_LO;
      end
      ST_SW: begin
        wdata      = data;
        misaligned = (off != 2'd0);
        be         = BE_WORD;
      end
`ifdef STORE_NARROW_SWLR_EN
      ST_SWL: begin
        wdata = data >> sh_l;
        be    = BE_WORD >> (2'd3 - lane);
      end
      ST_SWR: begin
        wdata = data << sh_r;
        be    = BE_WORD << lane;
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/store_narrow_unit.sv
// Store narrowing unit: lane generation, registered memory-write port with a one-entry skid.
// Build option STORE_NARROW_SWLR_EN enables SWL/SWR in the lane generator.
module store_narrow_unit
  import store_narrow_unit_pkg::*;
#(
  parameter int BIG_ENDIAN = 0,
  parameter int ADDR_W     = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_data,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_be,
  output logic              exc_valid,
  output logic [ADDR_W-1:0] exc_badvaddr
);

  logic [31:0]       lg_wdata;
  logic [3:0]        lg_be;
  logic              lg_mis;
  logic              skid_full;
  logic [ADDR_W-1:0] skid_addr;
  logic [31:0]       skid_wdata;
  logic [3:0]        skid_be;
  logic              accept;
  logic              wr;
  logic              out_free;
  logic [ADDR_W-1:0] word_addr;

  store_lane_gen #(.BIG_ENDIAN(BIG_ENDIAN)) u_lane_gen (
    .op         (req_op),
    .off        (req_addr[1:0]),
    .data       (req_data),
    .wdata      (lg_wdata),
    .be         (lg_be),
    .misaligned (lg_mis)
  );

  assign req_ready = !skid_full;
  assign accept    = req_valid && req_ready;
  // Reserved ops come out of the lane generator with no enables, so they drop here.
  assign wr        = accept && !lg_mis && (lg_be != 4'b0000);
  assign out_free  = !mem_valid || mem_ready;
  assign word_addr = {req_addr[ADDR_W-1:2], 2'b00};

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_valid    <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      mem_be       <= '0;
      exc_valid    <= 1'b0;
      exc_badvaddr <= '0;
      skid_full    <= 1'b0;
      skid_addr    <= '0;
      skid_wdata   <= '0;
      skid_be      <= '0;
    end else begin
      exc_valid <= accept && lg_mis;
      if (accept && lg_mis) exc_badvaddr <= req_addr;

      if (out_free) begin
        // Skid is only ever full while the output is stalled, so no accept races it.
        if (skid_full) begin
          mem_valid <= 1'b1;
          mem_addr  <= skid_addr;
          mem_wdata <= skid_wdata;
          mem_be    <= skid_be;
          skid_full <= 1'b0;
        end else if (wr) begin
          mem_valid <= 1'b1;
          mem_addr  <= word_addr;
          mem_wdata <= lg_wdata;
          mem_be    <= lg_be;
        end else begin
          mem_valid <= 1'b0;
        end
      end else if (wr) begin
        skid_full  <= 1'b1;
        skid_addr  <= word_addr;
        skid_wdata <= lg_wdata;
        skid_be    <= lg_be;
      end
    end
  end

endmodule

// File: tb/tb_store_narrow_unit.sv
// Randomized self-checking bench for store_narrow_unit against a byte-addressed store model.
// Directed SWL check is built when STORE_NARROW_SWLR_EN is defined.
module tb_store_narrow_unit;

  localparam int BIG = 0;
  localparam int AW  = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid;
  logic          req_ready;
  logic [2:0]    req_op;
  logic [AW-1:0] req_addr;
  logic [31:0]   req_data;
  logic          mem_valid;
  logic          mem_ready;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [3:0]    mem_be;
  logic          exc_valid;
  logic [AW-1:0] exc_badvaddr;

  always #5 clk = ~clk;

  store_narrow_unit #(.BIG_ENDIAN(BIG), .ADDR_W(AW)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_op       (req_op),
    .req_addr     (req_addr),
    .req_data     (req_data),
    .mem_valid    (mem_valid),
    .mem_ready    (mem_ready),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_be       (mem_be),
    .exc_valid    (exc_valid),
    .exc_badvaddr (exc_badvaddr)
  );

  int errors = 0;
  int checks = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] w;
  } wr_t;

  // Memory-order model: decide which byte addresses get which value, then map to lanes.
  // kind: 0 = dropped, 1 = memory write, 2 = address error
  function automatic void model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] d,
                                output int kind, output wr_t w);
    int off;
    logic [7:0] v[4];
    bit en[4];
    int lane;
    off  = int'(a[1:0]);
    kind = 1;
    for (int b = 0; b < 4; b++) begin en[b] = 0; v[b] = 8'h00; end
    case (op)
      3'd0: begin en[off] = 1; v[off] = d[7:0]; end
      3'd1: if (a[0]) kind = 2;
            else for (int k = 0; k < 2; k++) begin
              en[off+k] = 1;
              v[off+k]  = (BIG != 0) ? d[8*(1-k) +: 8] : d[8*k +: 8];
            end
      3'd2: if (off != 0) kind = 2;
            else for (int k = 0; k < 4; k++) begin
              en[k] = 1;
              v[k]  = (BIG != 0) ? d[8*(3-k) +: 8] : d[8*k +: 8];
            end
`ifdef STORE_NARROW_SWLR_EN
      3'd3: if (BIG == 0) for (int k = 0; k <= off; k++) begin en[off-k] = 1; v[off-k] = d[8*(3-k) +: 8]; end
            else for (int k = 0; k <= 3 - off; k++) begin en[off+k] = 1; v[off+k] = d[8*(3-k) +: 8]; end
      3'd4: if (BIG == 0) for (int k = 0; k <= 3 - off; k++) begin en[off+k] = 1; v[off+k] = d[8*k +: 8]; end
            else for (int k = 0; k <= off; k++) begin en[off-k] = 1; v[off-k] = d[8*k +: 8]; end
`endif
      default: kind = 0;
    endcase
    w.addr = {a[31:2], 2'b00};
    w.be   = 4'b0000;
    w.w    = 32'h0;
    for (int b = 0; b < 4; b++) begin
      if (en[b]) begin
        lane = (BIG != 0) ? 3 - b : b;
        w.be[lane] = 1'b1;
        w.w[8*lane +: 8] = v[b];
      end
    end
  endfunction

  function automatic logic [31:0] be_mask(input logic [3:0] be);
    logic [31:0] m;
    for (int i = 0; i < 4; i++) m[8*i +: 8] = be[i] ? 8'hFF : 8'h00;
    return m;
  endfunction

  wr_t         q[$];
  bit          chk_en = 0;
  bit          exc_exp = 0;
  logic [31:0] exc_addr_exp;
  bit          stall_prev = 0;
  logic [31:0] s_addr, s_w;
  logic [3:0]  s_be;

  always @(negedge clk) begin
    wr_t w;
    int kind;
    if (chk_en) begin
      check32("mem_valid", 32'(mem_valid), 32'(q.size() != 0));
      check32("req_ready", 32'(req_ready), 32'(q.size() < 2));
      check32("exc_valid", 32'(exc_valid), 32'(exc_exp));
      if (exc_exp) check32("exc_badvaddr", exc_badvaddr, exc_addr_exp);
      if (mem_valid && q.size() != 0) begin
        check32("mem_addr", mem_addr, q[0].addr);
        check32("mem_be", 32'(mem_be), 32'(q[0].be));
        check32("mem_wdata", mem_wdata & be_mask(q[0].be), q[0].w);
      end
      if (stall_prev) begin
        check32("stall_addr", mem_addr, s_addr);
        check32("stall_wdata", mem_wdata, s_w);
        check32("stall_be", 32'(mem_be), 32'(s_be));
      end
      stall_prev = !reset && mem_valid && !mem_ready;
      s_addr = mem_addr; s_w = mem_wdata; s_be = mem_be;
      exc_exp = 0;
      if (reset) q.delete();
      else begin
        if (mem_valid && mem_ready && q.size() != 0) void'(q.pop_front());
        if (req_valid && req_ready) begin
          model(req_op, req_addr, req_data, kind, w);
          if (kind == 1) q.push_back(w);
          else if (kind == 2) begin exc_exp = 1; exc_addr_exp = req_addr; end
        end
      end
    end
  end

  task automatic drive(input logic v, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] d, input logic mr, input logic rst);
    @(posedge clk);
    #1;
    req_valid = v; req_op = op; req_addr = a; req_data = d; mem_ready = mr; reset = rst;
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_op = 3'd0; req_addr = '0; req_data = '0; mem_ready = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk_en = 1;
    check32("rst_mem_valid", 32'(mem_valid), 32'h0);
    check32("rst_mem_addr", mem_addr, 32'h0);
    check32("rst_mem_wdata", mem_wdata, 32'h0);
    check32("rst_mem_be", 32'(mem_be), 32'h0);
    check32("rst_exc_badvaddr", exc_badvaddr, 32'h0);
    check32("rst_req_ready", 32'(req_ready), 32'h1);
    drive(0, 3'd0, 32'h0, 32'h0, 1, 0);

    drive(1, 3'd0, 32'h1003, 32'hAABBCCDD, 1, 0);
    drive(0, 3'd0, 32'h0, 32'h0, 1, 0);
    check32("sb_valid", 32'(mem_valid), 32'h1);
    check32("sb_addr", mem_addr, 32'h1000);
    check32("sb_be", 32'(mem_be), 32'h8);
    check32("sb_wdata", mem_wdata, 32'hDDDDDDDD);

    drive(1, 3'd1, 32'h2002, 32'h1234ABCD, 1, 0);
    drive(0, 3'd0, 32'h0, 32'h0, 1, 0);
    check32("sh_be", 32'(mem_be), 32'hC);
    check32("sh_wdata", mem_wdata, 32'hABCDABCD);

    drive(1, 3'd1, 32'h2001, 32'h1234ABCD, 1, 0);
    drive(0, 3'd0, 32'h0, 32'h0, 1, 0);
    check32("mis_exc", 32'(exc_valid), 32'h1);
    check32("mis_badvaddr", exc_badvaddr, 32'h2001);
    check32("mis_no_write", 32'(mem_valid), 32'h0);
    drive(0, 3'd0, 32'h0, 32'h0, 1, 0);
    check32("mis_pulse_end", 32'(exc_valid), 32'h0);

    drive(1, 3'd2, 32'h3000, 32'h01020304, 0, 0);
    drive(1, 3'd2, 32'h3004, 32'h05060708, 0, 0);
    drive(0, 3'd0, 32'h0, 32'h0, 0, 0);
    check32("stall_ready_low", 32'(req_ready), 32'h0);
    check32("stall_first", mem_addr, 32'h3000);
    drive(0, 3'd0, 32'h0, 32'h0, 1, 0);
    drive(0, 3'd0, 32'h0, 32'h0, 1, 0);
    check32("drain_second", mem_addr, 32'h3004);
    check32("drain_second_wdata", mem_wdata, 32'h05060708);
    check32("drain_ready", 32'(req_ready), 32'h1);
    drive(0, 3'd0, 32'h0, 32'h0, 1, 0);

    for (int i = 0; i < 8; i++) begin
      drive(1, 3'd2, 32'h5000 + 32'(4 * i), $urandom, 1, 0);
      if (i > 0) begin
        check32("b2b_ready", 32'(req_ready), 32'h1);
        check32("b2b_valid", 32'(mem_valid), 32'h1);
        check32("b2b_addr", mem_addr, 32'h5000 + 32'(4 * (i - 1)));
      end
    end
    drive(0, 3'd0, 32'h0, 32'h0, 1, 0);
    drive(0, 3'd0, 32'h0, 32'h0, 1, 0);

    drive(1, 3'd2, 32'h6000, 32'h11111111, 0, 0);
    drive(1, 3'd2, 32'h6004, 32'h22222222, 0, 0);
    drive(0, 3'd0, 32'h0, 32'h0, 0, 0);
    check32("rstmid_skid_full", 32'(req_ready), 32'h0);
    drive(0, 3'd0, 32'h0, 32'h0, 0, 1);
    drive(0, 3'd0, 32'h0, 32'h0, 1, 0);
    check32("rstmid_valid", 32'(mem_valid), 32'h0);
    check32("rstmid_ready", 32'(req_ready), 32'h1);
    repeat (3) drive(0, 3'd0, 32'h0, 32'h0, 1, 0);
    check32("rstmid_no_stale", 32'(mem_valid), 32'h0);

`ifdef STORE_NARROW_SWLR_EN
    drive(1, 3'd3, 32'h4001, 32'h11223344, 1, 0);
    drive(0, 3'd0, 32'h0, 32'h0, 1, 0);
    check32("swl_be", 32'(mem_be), 32'h3);
    check32("swl_wdata_lo", 32'(mem_wdata[15:0]), 32'h1122);
`else
    drive(1, 3'd3, 32'h4001, 32'h11223344, 1, 0);
    drive(0, 3'd0, 32'h0, 32'h0, 1, 0);
    check32("swl_off_dropped", 32'(mem_valid), 32'h0);
    check32("swl_off_no_exc", 32'(exc_valid), 32'h0);
`endif

    repeat (3000) begin
      logic [2:0] op;
      op = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 2)) : 3'($urandom_range(3, 7));
      drive($urandom_range(0, 3) != 0, op, $urandom, $urandom,
            $urandom_range(0, 3) != 0, $urandom_range(0, 199) == 0);
    end
    repeat (4) drive(0, 3'd0, 32'h0, 32'h0, 1, 0);
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
